// File: rtl/gcd_control_if.sv
// gcd_control_if: operand/result handshakes, datapath status flags and datapath controls
// that connect gcd_control to its operand source, result consumer and GCD datapath.
interface gcd_control_if #(parameter int CNT_W = 18);
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             zero;
  logic             lt;
  logic [1:0]       mux_sel_A;
  logic             mux_sel_B;
  logic             A_reg_en;
  logic             B_reg_en;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] iter_cnt;
  modport master (
    input  in_valid, out_ready, zero, lt,
    output in_ready, out_valid, mux_sel_A, mux_sel_B, A_reg_en, B_reg_en, busy, err, iter_cnt
  );
  modport slave (
    output in_valid, out_ready, zero, lt,
    input  in_ready, out_valid, mux_sel_A, mux_sel_B, A_reg_en, B_reg_en, busy, err, iter_cnt
  );
endinterface

// File: rtl/gcd_control.sv
// gcd_control: IDLE/CALC/DONE sequencer for the 16-bit subtractive GCD datapath,
// with operand/result valid-ready handshakes and an iteration-limit abort.
module gcd_control #(
  parameter int CNT_W    = 18,
  parameter int MAX_ITER = 262143
) (
  input logic           clk,
  input logic           rst_n,
  gcd_control_if.master ctl
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_ITER);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_iter_cnt, w_iter_cnt;
  logic             r_err, w_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_iter_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_iter_cnt <= w_iter_cnt;
      r_err      <= w_err;
    end
  // Outputs are gated by rst_n so the datapath is frozen while reset is held.
  always_comb begin
    w_next        = r_state;
    w_iter_cnt    = r_iter_cnt;
    w_err         = r_err;
    ctl.in_ready  = 1'b0;
    ctl.out_valid = 1'b0;
    ctl.busy      = 1'b0;
    ctl.mux_sel_A = 2'b11;
    ctl.mux_sel_B = 1'b0;
    ctl.A_reg_en  = 1'b0;
    ctl.B_reg_en  = 1'b0;
    if (rst_n)
      case (r_state)
        IDLE: begin
          ctl.in_ready = 1'b1;
          if (ctl.in_valid) begin
            ctl.mux_sel_A = 2'b00;
            ctl.A_reg_en  = 1'b1;
            ctl.B_reg_en  = 1'b1;
            w_iter_cnt    = '0;
            w_err         = 1'b0;
            w_next        = CALC;
          end
        end
        CALC: begin
          ctl.busy = 1'b1;
          if (r_iter_cnt == LAST && !ctl.zero) begin
            w_err      = 1'b1;
            w_iter_cnt = MAXC;
            w_next     = DONE;
          end else begin
            w_iter_cnt = r_iter_cnt + 1'b1;
            if (ctl.lt) begin
              ctl.mux_sel_A = 2'b01;
              ctl.mux_sel_B = 1'b1;
              ctl.A_reg_en  = 1'b1;
              ctl.B_reg_en  = 1'b1;
            end else if (!ctl.zero) begin
              ctl.mux_sel_A = 2'b10;
              ctl.A_reg_en  = 1'b1;
            end else
              w_next = DONE;
          end
        end
        DONE: begin
          ctl.out_valid = 1'b1;
          w_next        = ctl.out_ready ? IDLE : DONE;
        end
        default: w_next = IDLE;
      endcase
  end
  assign ctl.iter_cnt = r_iter_cnt;
  assign ctl.err      = r_err;
endmodule

// File: tb/tb_gcd_control.sv
// tb_gcd_control: two controllers (default limit and MAX_ITER=4) each driving a
// behavioural datapath, checked by vector table, corner sequences and random operands.
module tb_gcd_control;
  localparam int MX0 = 262143;
  localparam int MX1 = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gcd_control_if #(.CNT_W(18)) if0 ();
  gcd_control_if #(.CNT_W(3))  if1 ();
  gcd_control #(.CNT_W(18), .MAX_ITER(MX0)) dut0 (.clk(clk), .rst_n(rst_n), .ctl(if0));
  gcd_control #(.CNT_W(3),  .MAX_ITER(MX1)) dut1 (.clk(clk), .rst_n(rst_n), .ctl(if1));
  logic        iv[2], ordy[2], ir[2], ov[2], bsy[2], er[2], ae[2], be[2], msb[2];
  logic [1:0]  msa[2];
  logic [17:0] cnt[2];
  logic [15:0] ina[2], inb[2], ra[2], rb[2];
  assign if0.in_valid  = iv[0];
  assign if1.in_valid  = iv[1];
  assign if0.out_ready = ordy[0];
  assign if1.out_ready = ordy[1];
  assign if0.zero      = rb[0] == 16'd0;
  assign if1.zero      = rb[1] == 16'd0;
  assign if0.lt        = ra[0] < rb[0];
  assign if1.lt        = ra[1] < rb[1];
  assign ir[0]  = if0.in_ready;   assign ir[1]  = if1.in_ready;
  assign ov[0]  = if0.out_valid;  assign ov[1]  = if1.out_valid;
  assign bsy[0] = if0.busy;       assign bsy[1] = if1.busy;
  assign er[0]  = if0.err;        assign er[1]  = if1.err;
  assign ae[0]  = if0.A_reg_en;   assign ae[1]  = if1.A_reg_en;
  assign be[0]  = if0.B_reg_en;   assign be[1]  = if1.B_reg_en;
  assign msa[0] = if0.mux_sel_A;  assign msa[1] = if1.mux_sel_A;
  assign msb[0] = if0.mux_sel_B;  assign msb[1] = if1.mux_sel_B;
  assign cnt[0] = if0.iter_cnt;   assign cnt[1] = 18'(if1.iter_cnt);
  // Behavioural GCD datapath: vout is register A.
  always_ff @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (ae[k]) ra[k] <= msa[k] == 2'b00 ? ina[k] : msa[k] == 2'b01 ? rb[k] :
                          msa[k] == 2'b10 ? ra[k] - rb[k] : ra[k];
      if (be[k]) rb[k] <= msb[k] ? ra[k] : inb[k];
    end
  int errs = 0;
  int checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Reference: Euclid by repeated subtraction, one step per CALC cycle, capped at mx.
  function automatic void ref_gcd(input int unsigned a0, input int unsigned b0, input int unsigned mx,
                                  output int unsigned v, output int unsigned n, output bit e);
    int unsigned a, b, t;
    a = a0; b = b0; n = 0; e = 1'b0;
    while (1'b1) begin
      if (n == mx - 1 && b != 0) begin
        e = 1'b1;
        n = mx;
        break;
      end
      n++;
      if (a < b) begin
        t = a; a = b; b = t;
      end else if (b != 0) a = a - b;
      else break;
    end
    v = a;
  endfunction
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input int ev, input int en, input bit ee, input int hold);
    int lat = 0;
    chk("idle_in_ready", ir[k], 1);
    ina[k] = a; inb[k] = b; iv[k] = 1'b1;
    do begin
      tick();
      lat++;
      iv[k] = 1'b0;
    end while (!ov[k] && lat < en + 20);
    chk("latency", lat, en + 1);
    chk("vout", ra[k], ev);
    chk("iter_cnt", cnt[k], en);
    chk("err", er[k], ee);
    chk("busy_done", bsy[k], 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", ov[k], 1);
      chk("hold_vout", ra[k], ev);
      chk("hold_cnt", cnt[k], en);
      chk("hold_in_ready", ir[k], 0);
    end
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    chk("release_in_ready", ir[k], 1);
    chk("release_valid", ov[k], 0);
  endtask
  typedef struct {int k; logic [15:0] a; logic [15:0] b; int ev; int en; bit ee; int hold;} vec_t;
  vec_t vt[9];
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int unsigned v, n;
    bit e;
    int k;
    logic [15:0] a, b;
    vt[0] = '{0, 16'd12,    16'd8,  4,     6, 1'b0, 0};
    vt[1] = '{0, 16'd7,     16'd0,  7,     1, 1'b0, 0};
    vt[2] = '{0, 16'd0,     16'd5,  5,     2, 1'b0, 0};
    vt[3] = '{0, 16'd0,     16'd0,  0,     1, 1'b0, 0};
    vt[4] = '{0, 16'd12,    16'd8,  4,     6, 1'b0, 10};
    vt[5] = '{1, 16'd65535, 16'd1,  65532, 4, 1'b1, 0};
    vt[6] = '{1, 16'd9,     16'd6,  3,     4, 1'b1, 0};
    vt[7] = '{1, 16'd6,     16'd3,  3,     4, 1'b0, 0};
    vt[8] = '{0, 16'd9,     16'd6,  3,     6, 1'b0, 2};
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b1; ordy[i] = 1'b0; ina[i] = 16'd5; inb[i] = 16'd3;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", ir[i], 0);
      chk("rst_out_valid", ov[i], 0);
      chk("rst_busy", bsy[i], 0);
      chk("rst_a_en", ae[i], 0);
      chk("rst_b_en", be[i], 0);
      chk("rst_sel_a", msa[i], 2'b11);
      chk("rst_sel_b", msb[i], 0);
      chk("rst_iter_cnt", cnt[i], 0);
      chk("rst_err", er[i], 0);
      iv[i] = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++)
      run_op(vt[i].k, vt[i].a, vt[i].b, vt[i].ev, vt[i].en, vt[i].ee, vt[i].hold);
    // in_valid held high through DONE: exactly one acceptance every three cycles for (7,0)
    ina[0] = 16'd7; inb[0] = 16'd0; iv[0] = 1'b1; ordy[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("hs_in_ready", ir[0], c % 3 == 0);
      chk("hs_out_valid", ov[0], c % 3 == 2);
      if (c % 3 == 2) chk("hs_iter_cnt", cnt[0], 1);
      tick();
    end
    iv[0] = 1'b0; ordy[0] = 1'b0;
    // asynchronous reset in the middle of a long computation
    ina[0] = 16'd65535; inb[0] = 16'd1; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    chk("calc_busy", bsy[0], 1);
    chk("calc_sub_en", ae[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_en", ae[0], 0);
    chk("mid_rst_b_en", be[0], 0);
    chk("mid_rst_busy", bsy[0], 0);
    chk("mid_rst_cnt", cnt[0], 0);
    chk("mid_rst_in_ready", ir[0], 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", ir[0], 1);
    run_op(0, 16'd21, 16'd14, 7, 6, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      k = i % 2;
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = 16'd0;
      if ($urandom_range(0, 7) == 0) b = 16'd0;
      ref_gcd(a, b, k == 1 ? MX1 : MX0, v, n, e);
      run_op(k, a, b, int'(v), int'(n), e, int'($urandom_range(0, 2)));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
